// File: rtl/blink_funcmod.sv
// LED blink burst generator: a Call request becomes NBLINK timed ON/OFF blinks,
// fast for a short request and slow for a long one, ending with a Done pulse.
module blink_funcmod #(
    parameter logic [24:0] T_SHORT = 25'd5_000_000,
    parameter logic [24:0] T_LONG  = 25'd25_000_000,
    parameter logic [3:0]  NBLINK  = 4'd3
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic [1:0] iCall,
    output logic       oDone,
    output logic       oBusy,
    output logic       oLED
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ON      = 3'd1,
        OFF     = 3'd2,
        DONE    = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t      state, state_d;
    logic [24:0] c1, c1_d;
    logic [3:0]  n, n_d;
    logic        mode, mode_d;
    logic        led, led_d;
    logic        done, done_d;
    logic        busy, busy_d;
    logic [24:0] tc;

    // Terminal count of the phase counter for the latched mode
    assign tc = mode ? (T_LONG - 25'd1) : (T_SHORT - 25'd1);

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
            c1    <= '0;
            n     <= '0;
            mode  <= 1'b0;
            led   <= 1'b0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_d;
            c1    <= c1_d;
            n     <= n_d;
            mode  <= mode_d;
            led   <= led_d;
            done  <= done_d;
            busy  <= busy_d;
        end
    end

    always_comb begin
        state_d = state;
        c1_d    = c1;
        n_d     = n;
        mode_d  = mode;
        led_d   = led;
        done_d  = 1'b0;
        busy_d  = busy;
        unique case (state)
            IDLE: begin
                if (iCall != 2'b00) begin
                    mode_d  = iCall[1];
                    c1_d    = '0;
                    n_d     = '0;
                    led_d   = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ON;
                end
            end
            ON: begin
                if (c1 == tc) begin
                    c1_d    = '0;
                    led_d   = 1'b0;
                    state_d = OFF;
                end else begin
                    c1_d = c1 + 25'd1;
                end
            end
            OFF: begin
                if (c1 == tc) begin
                    c1_d = '0;
                    if (n == NBLINK - 4'd1) begin
                        state_d = DONE;
                    end else begin
                        n_d     = n + 4'd1;
                        led_d   = 1'b1;
                        state_d = ON;
                    end
                end else begin
                    c1_d = c1 + 25'd1;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = RELEASE;
            end
            RELEASE: begin
                // Wait for the caller to drop its request so a held level cannot retrigger
                if (iCall == 2'b00) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign oLED  = led;
    assign oDone = done;
    assign oBusy = busy;

endmodule

// File: tb/tb_blink_funcmod.sv
// Directed bench for blink_funcmod with short phases (T_SHORT=4, T_LONG=10, NBLINK=2).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_blink_funcmod;

    localparam int TS = 4;
    localparam int TL = 10;
    localparam int NB = 2;

    logic       CLOCK;
    logic       RESET;
    logic [1:0] iCall;
    logic       oDone;
    logic       oBusy;
    logic       oLED;

    int checks;
    int failures;

    blink_funcmod #(
        .T_SHORT(25'd4),
        .T_LONG (25'd10),
        .NBLINK (4'd2)
    ) dut (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .iCall(iCall),
        .oDone(oDone),
        .oBusy(oBusy),
        .oLED (oLED)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Called on a falling edge. Edge 0 is the acceptance edge; after edge k
    // oLED is high while k < 2*t*NB and (k/t) is even; oDone after edge 2*t*NB+1.
    task automatic burst(input string name, input logic [1:0] call,
                         input logic [1:0] call2, input int t, input int hold);
        logic exp_led;
        iCall = call;
        @(posedge CLOCK);
        for (int k = 0; k <= 2 * t * NB; k++) begin
            @(negedge CLOCK);
            if (k == 1) iCall = call2;
            exp_led = (k < 2 * t * NB) && (((k / t) % 2) == 0);
            chk({name, "_led"}, oLED, exp_led);
            chk({name, "_busy"}, oBusy, 1'b1);
            chk({name, "_nodone"}, oDone, 1'b0);
        end
        @(negedge CLOCK);
        chk({name, "_done"}, oDone, 1'b1);
        chk({name, "_done_led"}, oLED, 1'b0);
        chk({name, "_done_busy"}, oBusy, 1'b1);
        for (int h = 0; h < hold; h++) begin
            @(negedge CLOCK);
            chk({name, "_hold_done"}, oDone, 1'b0);
            chk({name, "_hold_busy"}, oBusy, 1'b1);
            chk({name, "_hold_led"}, oLED, 1'b0);
        end
        iCall = 2'b00;
        @(negedge CLOCK);
        chk({name, "_rel_busy"}, oBusy, 1'b0);
        chk({name, "_rel_done"}, oDone, 1'b0);
        chk({name, "_rel_led"}, oLED, 1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        RESET    = 1'b0;
        iCall    = 2'b00;

        repeat (2) @(negedge CLOCK);
        chk("reset_led", oLED, 1'b0);
        chk("reset_busy", oBusy, 1'b0);
        chk("reset_done", oDone, 1'b0);
        RESET = 1'b1;
        repeat (3) @(negedge CLOCK);
        chk("idle_led", oLED, 1'b0);
        chk("idle_busy", oBusy, 1'b0);

        burst("short", 2'b01, 2'b01, TS, 0);
        repeat (2) @(negedge CLOCK);
        burst("long", 2'b10, 2'b10, TL, 0);
        repeat (2) @(negedge CLOCK);
        burst("prio", 2'b11, 2'b11, TL, 0);
        repeat (2) @(negedge CLOCK);
        burst("held", 2'b01, 2'b01, TS, 50);
        repeat (2) @(negedge CLOCK);
        burst("switch", 2'b01, 2'b10, TS, 0);
        repeat (2) @(negedge CLOCK);

        // Reset inside the second ON phase
        iCall = 2'b01;
        @(posedge CLOCK);
        for (int k = 0; k <= 2 * TS + 1; k++) @(negedge CLOCK);
        chk("mid_led_on", oLED, 1'b1);
        chk("mid_busy_on", oBusy, 1'b1);
        #2 RESET = 1'b0;
        #1;
        chk("async_led", oLED, 1'b0);
        chk("async_busy", oBusy, 1'b0);
        chk("async_done", oDone, 1'b0);
        iCall = 2'b00;
        repeat (3) @(negedge CLOCK);
        chk("rst_hold_done", oDone, 1'b0);
        RESET = 1'b1;
        repeat (2) @(negedge CLOCK);
        chk("post_rst_led", oLED, 1'b0);
        burst("after_rst", 2'b01, 2'b01, TS, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
